bpf_sweep_stimulus: RTL and testbench
=====================================

// Module: bpf_sweep_stimulus
// PURPOSE
//   Stepped-frequency stimulus generator for the HF band-pass filter S21 sweep (f0 = 14 MHz).
//   Phase-accumulator tone (triangle amplitude) feeds the DAC driving the filter input port.
//   Steps through n_points frequencies with per-point settle and dwell intervals.
//   Flags the dwell window, point index and current FCW so the downstream detector can tag its power readings.
// PARAMETERS
//   PHASE_W   32  phase accumulator and FCW width; frequency = fcw/2^PHASE_W * f_clk
//   OUT_W     12  signed sample width, OUT_W <= PHASE_W-1
//   CNT_W     16  settle/dwell counter width
//   NPTS_W    10  point counter width
// PORTS
//   clk           in   1        single clock; all logic on rising edge
//   rst           in   1        synchronous reset, active-high
//   start         in   1        one-cycle sweep request; honoured only in IDLE
//   abort         in   1        synchronous sweep cancel
//   f_start       in   PHASE_W  FCW of point 0
//   f_step        in   PHASE_W  FCW increment per point; unsigned, wraps mod 2^PHASE_W
//   n_points      in   NPTS_W   points per sweep
//   settle_cyc    in   CNT_W    cycles per point before measurement
//   dwell_cyc     in   CNT_W    measurement cycles per point (0 is treated as 1)
//   busy          out  1        high in every state except IDLE
//   sample        out  OUT_W    signed triangle sample
//   sample_valid  out  1        sample is live
//   meas_window   out  1        high during DWELL
//   point_idx     out  NPTS_W   index of the current point
//   cur_fcw       out  PHASE_W  FCW of the current point
//   point_done    out  1        one-cycle pulse at the end of each point
//   sweep_done    out  1        one-cycle pulse at normal sweep completion
// BEHAVIOUR
//   - Reset: state=IDLE, phase=0, all outputs 0, latched config cleared. Reset overrides abort and start.
//   - Config is latched on the start cycle in IDLE. Changing inputs mid-sweep has no effect.
//   - start while busy is ignored.
//   - FSM states: IDLE, SETTLE, DWELL, STEP, DONE.
//   - IDLE --start, n_points==0--> DONE.
//   - IDLE --start--> SETTLE. Entry: idx=0, fcw=f_start, phase=0, cnt=settle_cyc.
//       If settle_cyc==0, go directly to DWELL.
//   - SETTLE: lasts exactly settle_cyc cycles, then DWELL. cnt = max(dwell_cyc,1).
//   - DWELL: lasts max(dwell_cyc,1) cycles with meas_window=1, then STEP.
//   - STEP: one cycle with point_done=1.
//       If idx==n_points-1, next state is DONE.
//       Otherwise idx+=1, fcw+=f_step (mod 2^PHASE_W), then SETTLE (or DWELL if settle_cyc==0).
//   - DONE: one cycle with sweep_done=1, then IDLE.
//   - Cycle count: busy high for n*(settle+max(dwell,1)+1)+1 cycles.
//   - Phase: phase += fcw every cycle in SETTLE/DWELL/STEP. No reset between points (phase-continuous).
//       Held at 0 in IDLE/DONE.
//   - Amplitude: t = phase[MSB] ? ~phase[MSB-1 -: OUT_W] : phase[MSB-1 -: OUT_W]; sample = t - 2^(OUT_W-1).
//       Registered: sample reflects the phase of the previous cycle.
//   - sample_valid: 1 when the previous cycle was SETTLE/DWELL/STEP. When 0, sample=0.
//   - Outputs point_idx/cur_fcw/meas_window/point_done/sweep_done/busy are registered state decodes.
//       point_idx and cur_fcw hold their last values in IDLE until the next start.
//   - abort in any non-IDLE state: IDLE next cycle.
//       No point_done/sweep_done is emitted, phase=0, sample_valid drops the cycle after.
//       abort+start on the same cycle in IDLE: start wins.
// TESTING
//   1. Assert rst mid-DWELL -> next cycle all outputs 0, busy=0; a following start begins at idx 0.
//   2. f_start=0x01000000, f_step=0x01000000, n=3, settle=4, dwell=8 -> busy high exactly 40 cycles.
//        3 point_done pulses, 24 meas_window cycles, cur_fcw 0x01000000/0x02000000/0x03000000, 1 sweep_done.
//   3. fcw=0x00080000, long dwell -> sample -2048,-2047,... up to 2047, then falls to -2048.
//        Period 8192 cycles; first sample_valid one cycle after SETTLE entry.
//   4. n_points=0 -> busy and sweep_done high for exactly 1 cycle; no sample_valid.
//        settle=0, dwell=0, n=2 -> each point is DWELL 1 cycle + STEP; busy 5 cycles.
//   5. abort in DWELL of point 1 -> IDLE next cycle, no sweep_done.
//        start pulsed while busy -> ignored; point_idx sequence unchanged.
//   6. f_start=0xFFFFFFF0, f_step=0x20, n=2 -> cur_fcw 0xFFFFFFF0 then 0x00000010.
//        Phase continuity: no sample discontinuity at the point boundary beyond one step.

Source files
------------

// File: rtl/bpf_sweep_stimulus_if.sv
// Bus bundle for the band-pass filter sweep stimulus generator.
// The master side (sequencer/bench) supplies the sweep request and
// configuration; the slave side (the generator) returns the DAC sample
// stream and the tagging flags for the downstream power detector.
interface bpf_sweep_stimulus_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 12,
  parameter int CNT_W   = 16,
  parameter int NPTS_W  = 10
);

  logic                      start;
  logic                      abort;
  logic        [PHASE_W-1:0] f_start;
  logic        [PHASE_W-1:0] f_step;
  logic        [NPTS_W-1:0]  n_points;
  logic        [CNT_W-1:0]   settle_cyc;
  logic        [CNT_W-1:0]   dwell_cyc;

  logic                      busy;
  logic signed [OUT_W-1:0]   sample;
  logic                      sample_valid;
  logic                      meas_window;
  logic        [NPTS_W-1:0]  point_idx;
  logic        [PHASE_W-1:0] cur_fcw;
  logic                      point_done;
  logic                      sweep_done;

  modport master (
    output start, abort, f_start, f_step, n_points, settle_cyc, dwell_cyc,
    input  busy, sample, sample_valid, meas_window, point_idx, cur_fcw,
           point_done, sweep_done
  );

  modport slave (
    input  start, abort, f_start, f_step, n_points, settle_cyc, dwell_cyc,
    output busy, sample, sample_valid, meas_window, point_idx, cur_fcw,
           point_done, sweep_done
  );

endinterface

// File: rtl/bpf_sweep_stimulus.sv
// Stepped-frequency stimulus generator for the 14 MHz HF band-pass filter
// S21 sweep. A phase accumulator produces a triangle tone for the DAC; the
// sequencer walks n_points frequencies, each with a settle interval followed
// by a dwell (measurement) interval and a one-cycle step. The phase is kept
// continuous across point boundaries so the filter never sees a jump.
module bpf_sweep_stimulus #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 12,
  parameter int CNT_W   = 16,
  parameter int NPTS_W  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  bpf_sweep_stimulus_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DWELL,
    STEP,
    DONE
  } state_t;

  state_t               state;
  logic [PHASE_W-1:0]   phase;
  logic [PHASE_W-1:0]   step_reg;
  logic [NPTS_W-1:0]    npts_reg;
  logic [CNT_W-1:0]     settle_reg;
  logic [CNT_W-1:0]     dwell_reg;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     dwell_eff;
  logic [OUT_W-1:0]     tri_mag;
  logic                 tone_active;

  // Fold the upper phase bits into an unsigned triangle and clamp a zero dwell to one cycle.
  always_comb begin
    dwell_eff   = (bus.dwell_cyc == '0) ? CNT_W'(1) : bus.dwell_cyc;
    tri_mag     = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: OUT_W] : phase[PHASE_W-2 -: OUT_W];
    tone_active = (state == SETTLE) || (state == DWELL) || (state == STEP);
  end

  // Sweep sequencer: state, counters, phase accumulator and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      phase           <= '0;
      step_reg        <= '0;
      npts_reg        <= '0;
      settle_reg      <= '0;
      dwell_reg       <= '0;
      cnt             <= '0;
      bus.busy        <= 1'b0;
      bus.meas_window <= 1'b0;
      bus.point_idx   <= '0;
      bus.cur_fcw     <= '0;
      bus.point_done  <= 1'b0;
      bus.sweep_done  <= 1'b0;
    end else begin
      bus.point_done <= 1'b0;
      bus.sweep_done <= 1'b0;
      if ((state != IDLE) && bus.abort) begin
        state           <= IDLE;
        phase           <= '0;
        cnt             <= '0;
        bus.busy        <= 1'b0;
        bus.meas_window <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              step_reg      <= bus.f_step;
              npts_reg      <= bus.n_points;
              settle_reg    <= bus.settle_cyc;
              dwell_reg     <= dwell_eff;
              bus.point_idx <= '0;
              bus.cur_fcw   <= bus.f_start;
              phase         <= '0;
              bus.busy      <= 1'b1;
              if (bus.n_points == '0) begin
                state          <= DONE;
                bus.sweep_done <= 1'b1;
              end else if (bus.settle_cyc == '0) begin
                state           <= DWELL;
                cnt             <= dwell_eff;
                bus.meas_window <= 1'b1;
              end else begin
                state <= SETTLE;
                cnt   <= bus.settle_cyc;
              end
            end
          end

          SETTLE: begin
            phase <= phase + bus.cur_fcw;
            if (cnt == CNT_W'(1)) begin
              state           <= DWELL;
              cnt             <= dwell_reg;
              bus.meas_window <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end

          DWELL: begin
            phase <= phase + bus.cur_fcw;
            if (cnt == CNT_W'(1)) begin
              state           <= STEP;
              bus.meas_window <= 1'b0;
              bus.point_done  <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end

          STEP: begin
            if (bus.point_idx == npts_reg - NPTS_W'(1)) begin
              state          <= DONE;
              phase          <= '0;
              bus.sweep_done <= 1'b1;
            end else begin
              phase         <= phase + bus.cur_fcw;
              bus.point_idx <= bus.point_idx + NPTS_W'(1);
              bus.cur_fcw   <= bus.cur_fcw + step_reg;
              if (settle_reg == '0) begin
                state           <= DWELL;
                cnt             <= dwell_reg;
                bus.meas_window <= 1'b1;
              end else begin
                state <= SETTLE;
                cnt   <= settle_reg;
              end
            end
          end

          DONE: begin
            state    <= IDLE;
            phase    <= '0;
            bus.busy <= 1'b0;
          end

          default: begin
            state    <= IDLE;
            phase    <= '0;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // DAC sample register: offset-binary triangle becomes two's complement by flipping its MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= tone_active;
      bus.sample       <= tone_active ? {~tri_mag[OUT_W-1], tri_mag[OUT_W-2:0]} : '0;
    end
  end

endmodule

// File: tb/tb_bpf_sweep_stimulus.sv
// Self-checking bench for bpf_sweep_stimulus. Each sweep is described by a
// per-cycle expectation list built from the sweep rules (points x settle /
// dwell / step, phase advancing by the point's FCW), then the DUT is run
// against that list one cycle at a time.
module tb_bpf_sweep_stimulus;

  localparam int PHASE_W = 32;
  localparam int OUT_W   = 12;
  localparam int CNT_W   = 16;
  localparam int NPTS_W  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  bpf_sweep_stimulus_if #(
    .PHASE_W(PHASE_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .NPTS_W(NPTS_W)
  ) bus ();

  bpf_sweep_stimulus #(
    .PHASE_W(PHASE_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .NPTS_W(NPTS_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          busy;
    bit          meas;
    bit          pd;
    bit          sd;
    bit          active;
    bit          clr;
    bit          chk;
    logic [9:0]  idx;
    logic [31:0] fcw;
    logic [31:0] phase;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   obs_busy, obs_pd, obs_meas, obs_sd, obs_valid;

  function automatic rec_t mk(bit busy, bit meas, bit pd, bit sd, bit active,
                              logic [9:0] idx, logic [31:0] fcw, logic [31:0] ph, bit chk);
    rec_t r;
    r.busy   = busy;
    r.meas   = meas;
    r.pd     = pd;
    r.sd     = sd;
    r.active = active;
    r.clr    = 1'b0;
    r.chk    = chk;
    r.idx    = idx;
    r.fcw    = fcw;
    r.phase  = ph;
    return r;
  endfunction

  // Triangle of the top 13 phase bits: rises 0..4095 then falls 4095..0, offset to signed.
  function automatic logic [11:0] tri_ref(logic [31:0] ph);
    int u;
    int t;
    u = int'(ph >> 19);
    t = (u < 4096) ? u : 8191 - u;
    return 12'(t - 2048);
  endfunction

  // Expected per-cycle trace of one full sweep, starting the cycle after start is taken.
  function automatic void build_model(logic [31:0] fs, logic [31:0] fst, int n, int settle, int dwell);
    logic [31:0] fcw;
    logic [31:0] ph;
    int          d;
    exp_q.delete();
    d   = (dwell == 0) ? 1 : dwell;
    fcw = fs;
    ph  = 32'h0;
    if (n == 0) begin
      exp_q.push_back(mk(1, 0, 0, 1, 0, 10'h0, fs, 32'h0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 10'h0, fs, 32'h0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 10'h0, fs, 32'h0, 0));
    end else begin
      for (int p = 0; p < n; p++) begin
        for (int c = 0; c < settle; c++) begin
          exp_q.push_back(mk(1, 0, 0, 0, 1, 10'(p), fcw, ph, 1));
          ph = ph + fcw;
        end
        for (int c = 0; c < d; c++) begin
          exp_q.push_back(mk(1, 1, 0, 0, 1, 10'(p), fcw, ph, 1));
          ph = ph + fcw;
        end
        exp_q.push_back(mk(1, 0, 1, 0, 1, 10'(p), fcw, ph, 1));
        ph = ph + fcw;
        if (p < n - 1) fcw = fcw + fst;
      end
      exp_q.push_back(mk(1, 0, 0, 1, 0, 10'(n - 1), fcw, 32'h0, 1));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 10'(n - 1), fcw, 32'h0, 1));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 10'(n - 1), fcw, 32'h0, 1));
    end
  endfunction

  task automatic check_output(input string name, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s@%0d got=%0h exp=%0h", name, k, obs, exp);
    end
  endtask

  task automatic compare_cycle(input int k);
    rec_t        e;
    bit          v;
    logic [11:0] s;
    e = exp_q[k];
    v = (k > 0) && exp_q[k-1].active && !e.clr;
    s = v ? tri_ref(exp_q[k-1].phase) : 12'h0;
    check_output("busy",         k, {31'b0, bus.busy},         {31'b0, e.busy});
    check_output("meas_window",  k, {31'b0, bus.meas_window},  {31'b0, e.meas});
    check_output("point_done",   k, {31'b0, bus.point_done},   {31'b0, e.pd});
    check_output("sweep_done",   k, {31'b0, bus.sweep_done},   {31'b0, e.sd});
    check_output("sample_valid", k, {31'b0, bus.sample_valid}, {31'b0, v});
    check_output("sample",       k, {20'b0, bus.sample},       {20'b0, s});
    if (e.chk) begin
      check_output("point_idx", k, {22'b0, bus.point_idx}, {22'b0, e.idx});
      check_output("cur_fcw",   k, bus.cur_fcw,            e.fcw);
    end
  endtask

  // Run one sweep; abort_at/rst_at/junk_at (cycle index, -1 = none) inject events after that cycle.
  task automatic apply_stimulus(input logic [31:0] fs, input logic [31:0] fst, input int n,
                                input int settle, input int dwell, input int abort_at,
                                input int rst_at, input int junk_at, input bit abort_on_start);
    rec_t r;
    build_model(fs, fst, n, settle, dwell);
    if (abort_at >= 0) begin
      r = exp_q[abort_at];
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 0, 0, 0, 0, r.idx, r.fcw, 32'h0, 1));
      exp_q.push_back(mk(0, 0, 0, 0, 0, r.idx, r.fcw, 32'h0, 1));
    end
    if (rst_at >= 0) begin
      while (exp_q.size() > rst_at + 1) void'(exp_q.pop_back());
      r = mk(0, 0, 0, 0, 0, 10'h0, 32'h0, 32'h0, 1);
      r.clr = 1'b1;
      exp_q.push_back(r);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 10'h0, 32'h0, 32'h0, 1));
    end
    obs_busy = 0; obs_pd = 0; obs_meas = 0; obs_sd = 0; obs_valid = 0;

    @(negedge clk);
    bus.f_start    = fs;
    bus.f_step     = fst;
    bus.n_points   = 10'(n);
    bus.settle_cyc = 16'(settle);
    bus.dwell_cyc  = 16'(dwell);
    bus.start      = 1'b1;
    bus.abort      = abort_on_start;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;

    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      compare_cycle(k);
      if (bus.busy)         obs_busy++;
      if (bus.point_done)   obs_pd++;
      if (bus.meas_window)  obs_meas++;
      if (bus.sweep_done)   obs_sd++;
      if (bus.sample_valid) obs_valid++;
      bus.f_start    = $urandom();
      bus.f_step     = $urandom();
      bus.n_points   = 10'($urandom());
      bus.settle_cyc = 16'($urandom());
      bus.dwell_cyc  = 16'($urandom());
      bus.start      = (k == junk_at);
      bus.abort      = (k == abort_at);
      rst            = (k == rst_at);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    int n, s, d;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.f_start    = '0;
    bus.f_step     = '0;
    bus.n_points   = '0;
    bus.settle_cyc = '0;
    bus.dwell_cyc  = '0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] reset state");
    @(negedge clk);
    check_output("rst_busy",   0, {31'b0, bus.busy},         32'h0);
    check_output("rst_sample", 0, {20'b0, bus.sample},       32'h0);
    check_output("rst_valid",  0, {31'b0, bus.sample_valid}, 32'h0);
    check_output("rst_meas",   0, {31'b0, bus.meas_window},  32'h0);
    check_output("rst_idx",    0, {22'b0, bus.point_idx},    32'h0);
    check_output("rst_fcw",    0, bus.cur_fcw,               32'h0);
    check_output("rst_pd",     0, {31'b0, bus.point_done},   32'h0);
    check_output("rst_sd",     0, {31'b0, bus.sweep_done},   32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] three-point sweep, settle 4 dwell 8");
    apply_stimulus(32'h01000000, 32'h01000000, 3, 4, 8, -1, -1, -1, 1'b0);
    check_output("t2_busy_cycles", 0, obs_busy, 40);
    check_output("t2_point_done",  0, obs_pd,   3);
    check_output("t2_meas_cycles", 0, obs_meas, 24);
    check_output("t2_sweep_done",  0, obs_sd,   1);

    $display("[TB] reset mid-dwell, then fresh sweep");
    apply_stimulus(32'h00400000, 32'h00100000, 3, 4, 8, -1, 7, -1, 1'b0);
    check_output("t1_sweep_done", 0, obs_sd, 0);
    apply_stimulus(32'h00A00000, 32'h00200000, 2, 2, 3, -1, -1, -1, 1'b0);

    $display("[TB] full triangle period");
    apply_stimulus(32'h00080000, 32'h0, 1, 2, 9000, -1, -1, -1, 1'b0);

    $display("[TB] zero points and zero settle/dwell");
    apply_stimulus(32'h12345678, 32'h1, 0, 3, 3, -1, -1, -1, 1'b0);
    check_output("t4_busy_cycles", 0, obs_busy,  1);
    check_output("t4_sweep_done",  0, obs_sd,    1);
    check_output("t4_valid",       0, obs_valid, 0);
    apply_stimulus(32'h01000000, 32'h01000000, 2, 0, 0, -1, -1, -1, 1'b0);
    check_output("t4b_busy_cycles", 0, obs_busy, 5);
    check_output("t4b_point_done",  0, obs_pd,   2);

    $display("[TB] abort in point 1 dwell, start while busy");
    apply_stimulus(32'h02000000, 32'h00800000, 3, 3, 5, 13, -1, 5, 1'b0);
    check_output("t5_sweep_done", 0, obs_sd, 0);
    check_output("t5_point_done", 0, obs_pd, 1);

    $display("[TB] FCW wrap");
    apply_stimulus(32'hFFFFFFF0, 32'h00000020, 2, 1, 3, -1, -1, -1, 1'b0);

    $display("[TB] abort and start together in idle");
    apply_stimulus(32'h00300000, 32'h00010000, 2, 1, 2, -1, -1, -1, 1'b1);
    check_output("t7_sweep_done", 0, obs_sd, 1);

    $display("[TB] randomized sweeps");
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(1, 4);
      s = $urandom_range(0, 5);
      d = $urandom_range(0, 6);
      apply_stimulus($urandom(), $urandom(), n, s, d, -1, -1, $urandom_range(0, 2), 1'b0);
      check_output("rnd_busy_cycles", i, obs_busy, n * (s + ((d == 0) ? 1 : d) + 1) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
